// File: rtl/mem_io_pkg.sv
// Shared definitions for the memory / I/O slave: bus command codes,
// controller states and the memory-mapped register addresses.
package mem_io_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR  = 9'h140;

endpackage

// File: rtl/ram_sync.sv
// Single-port synchronous RAM with write enable and a read register that
// only updates when a read is requested, so the last read word is held.
module ram_sync #(
  parameter int WORDS  = 256,
  parameter int DATA_W = 16,
  parameter int AW     = $clog2(WORDS)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/mem_io_bus.sv
// Memory and I/O slave behind the CPU memory port. Boot-loads RAM from a
// word stream while holding the CPU in reset, then serves RAM/LED/switch accesses.
module mem_io_bus #(
  parameter int                ADDR_W    = 9,
  parameter int                DATA_W    = 16,
  parameter int                RAM_WORDS = 256,
  parameter logic [ADDR_W-1:0] LED_ADDR  = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR   = 9'h140
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  input  logic [9:0]        sw_in,
  output logic [7:0]        led_out,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              ld_done,
  output logic              cpu_reset,
  output logic              bus_err,
  output logic [1:0]        dbg_state
);
  import mem_io_pkg::*;

  localparam int                RAM_AW   = $clog2(RAM_WORDS);
  localparam int                PTR_W    = RAM_AW + 1;
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(RAM_WORDS - 1);
  localparam logic [PTR_W-1:0]  PTR_FULL = PTR_W'(RAM_WORDS);
  localparam logic [ADDR_W-1:0] RAM_TOP  = ADDR_W'(RAM_WORDS);

  // Loader handshake: a word transfers on any edge where ld_valid and
  // ld_ready are both high; ld_ready is only ever raised in LOAD.
  state_t              r_state;
  state_t              w_state_nxt;
  logic [PTR_W-1:0]    r_load_ptr;
  logic [9:0]          r_sw_meta;
  logic [9:0]          r_sw_sync;
  logic [7:0]          r_led;
  logic                r_bus_err;
  logic                r_src_ram;
  logic [DATA_W-1:0]   r_reg_data;
  logic                w_ld_fire;
  logic                w_in_ram;
  logic                w_ram_we;
  logic                w_ram_re;
  logic [RAM_AW-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   w_ram_wdata;
  logic [DATA_W-1:0]   w_ram_rdata;

  assign w_in_ram  = (mem_addr < RAM_TOP);
  assign ld_ready  = (r_state == LOAD) && (r_load_ptr < PTR_FULL);
  assign cpu_reset = (r_state != RUN);
  assign led_out   = r_led;
  assign bus_err   = r_bus_err;
  assign dbg_state = r_state;
  assign read_data = r_src_ram ? w_ram_rdata : r_reg_data;

  always_comb begin
    w_state_nxt = r_state;
    w_ld_fire   = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_addr  = r_load_ptr[RAM_AW-1:0];
    w_ram_wdata = ld_data;
    case (r_state)
      LOAD: begin
        w_ld_fire = ld_valid && ld_ready;
        w_ram_we  = w_ld_fire;
        if (ld_done || (w_ld_fire && (r_load_ptr == PTR_LAST))) w_state_nxt = RELEASE;
      end
      RELEASE: w_state_nxt = RUN;
      RUN: begin
        w_ram_addr  = mem_addr[RAM_AW-1:0];
        w_ram_wdata = write_data;
        w_ram_we    = (mem_cmd == MWRITE) && w_in_ram;
        w_ram_re    = (mem_cmd == MREAD) && w_in_ram;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= LOAD;
      r_load_ptr <= '0;
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_led      <= '0;
      r_bus_err  <= 1'b0;
      r_src_ram  <= 1'b0;
      r_reg_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
      if (w_ld_fire) r_load_ptr <= r_load_ptr + 1'b1;
      // read_data source is chosen per read; RAM reads come from the RAM's own register.
      if (r_state == RUN) begin
        case (mem_cmd)
          MREAD: begin
            r_src_ram <= w_in_ram;
            if (!w_in_ram) begin
              if (mem_addr == LED_ADDR) r_reg_data <= {{(DATA_W-8){1'b0}}, r_led};
              else if (mem_addr == SW_ADDR) r_reg_data <= {{(DATA_W-10){1'b0}}, r_sw_sync};
              else begin
                r_reg_data <= '0;
                r_bus_err  <= 1'b1;
              end
            end
          end
          MWRITE: begin
            if (!w_in_ram) begin
              if (mem_addr == LED_ADDR) r_led <= write_data[7:0];
              else r_bus_err <= 1'b1;
            end
          end
          MNONE: ;
          default: r_bus_err <= 1'b1;
        endcase
      end
    end
  end

  ram_sync #(.WORDS(RAM_WORDS), .DATA_W(DATA_W), .AW(RAM_AW)) u_ram (
    .i_clk  (clk),
    .i_we   (w_ram_we),
    .i_re   (w_ram_re),
    .i_addr (w_ram_addr),
    .i_wdata(w_ram_wdata),
    .o_rdata(w_ram_rdata)
  );

endmodule

// File: doc/mem_io_bus.md
Name: mem_io_bus

Overview:
- Memory and I/O slave sitting directly downstream of the CPU's memory port; consumes mem_cmd / mem_addr / write data and returns read_data.
- Contains a synchronous program/data RAM plus memory-mapped LED and switch registers.
- Owns a boot-load state machine: fills RAM from a word-stream loader while holding the CPU in reset, then releases it.

Parameters:
- ADDR_W, 9, width of mem_addr.
- DATA_W, 16, data word width.
- RAM_WORDS, 256, RAM depth; RAM occupies addresses 0..RAM_WORDS-1.
- LED_ADDR, 9'h100, LED output register address.
- SW_ADDR, 9'h140, switch input address.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mem_cmd  in  2  00 MNONE, 01 MREAD, 10 MWRITE, 11 illegal.
- mem_addr  in  ADDR_W  word address.
- write_data  in  DATA_W  store data, sampled with MWRITE.
- read_data  out  DATA_W  load/fetch data.
- sw_in  in  10  asynchronous slide switches.
- led_out  out  8  LED register.
- ld_valid  in  1  loader word valid.
- ld_data  in  DATA_W  loader word.
- ld_ready  out  1  loader may present a word.
- ld_done  in  1  loader finished (single-cycle pulse).
- cpu_reset  out  1  active-high synchronous reset to CPU.
- bus_err  out  1  sticky error flag.

Behaviour:
- Reset (async, reset_n=0): state LOAD, load_ptr=0, led_out=0, read_data=0, bus_err=0, cpu_reset=1, switch synchroniser flops=0.
- States:
  - LOAD: cpu_reset=1; ld_ready=1 while load_ptr<RAM_WORDS.
  - RELEASE: cpu_reset=1, ld_ready=0; exactly one cycle, so the CPU sees a clock edge with reset high.
  - RUN: cpu_reset=0, ld_ready=0; terminal until reset_n.
- LOAD transfer: on an edge with ld_valid&ld_ready, RAM[load_ptr]<=ld_data and load_ptr++.
- LOAD exit: ld_done, or load_ptr reaching RAM_WORDS, -> RELEASE.
- ld_done with ld_valid&ld_ready in the same cycle: the word is written, then the transition happens.
- Full: ld_ready=0 and further ld_valid is ignored; no wrap-around.
- In LOAD/RELEASE, mem_cmd is ignored entirely: no writes, no bus_err, read_data unchanged.
- RUN, MREAD: address sampled at edge N; read_data updates after edge N and is stable through edge N+1 (fixed 1-cycle latency, registered output).
  - addr<RAM_WORDS: RAM word.
  - LED_ADDR: {8'b0, led_out}.
  - SW_ADDR: {6'b0, sw_sync}.
  - Any other address: 16'h0000 and bus_err<=1.
- RUN, MWRITE:
  - addr<RAM_WORDS: RAM[addr]<=write_data.
  - LED_ADDR: led_out<=write_data[7:0].
  - SW_ADDR or unmapped: no state change except bus_err<=1.
  - read_data holds.
- RUN, MNONE: read_data holds its last value.
- RUN, cmd 11: no access, read_data holds, bus_err<=1.
- bus_err is cleared only by reset_n.
- Switches: 2-flop synchroniser; an sw_in change is visible in the sw_sync register two edges later.
- Reset asserted mid-load: RAM contents are undefined/retained, load_ptr returns to 0, and the load restarts.

Decomposition:
- Package mem_io_pkg:
  - MNONE/MREAD/MWRITE constants (2'b00/01/10).
  - State enum {LOAD, RELEASE, RUN}.
  - Address-map constants LED_ADDR and SW_ADDR.
- Sub-module ram_sync: single-port synchronous RAM, RAM_WORDS x DATA_W, write enable, registered read. The port is muxed between the loader (LOAD) and the CPU (RUN).

Test Plan:
- Load 3 words 16'hD001, 16'hD102, 16'hE000, then pulse ld_done -> ld_ready drops; cpu_reset stays 1 for exactly one more edge (RELEASE), then 0.
- RUN, MREAD addr 1 -> read_data=16'hD102 one cycle later; then MNONE for 3 cycles -> read_data holds 16'hD102.
- MWRITE addr 9'h100, data 16'h12A5 -> led_out=8'hA5; MREAD 9'h100 -> read_data=16'h00A5; bus_err=0.
- sw_in=10'h2B3, wait 2 edges, MREAD 9'h140 -> read_data=16'h02B3.
- MREAD 9'h1FF -> read_data=16'h0000, bus_err=1. Later cmd 11 and valid accesses -> bus_err stays 1 until reset_n.
- Stream 256 valid words -> ld_ready=0 after the 256th; a 257th ld_valid is ignored and RAM[0] is not overwritten. Assert reset_n low mid-stream in a second run -> load_ptr restarts at 0 and cpu_reset=1.
